// File: rtl/vdp_mixer.sv
// Pixel compositor: merges sprite slot outputs over a background colour by index
// priority, re-aligns display timing, and tracks sticky sprite collisions.
module vdp_mixer #(
    parameter int unsigned N_SPRITES   = 8,
    parameter int unsigned RGB_WIDTH   = 3,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            display_on_in,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic [N_SPRITES-1:0]            sprite_rgb_en,
    input  logic [N_SPRITES*RGB_WIDTH-1:0]  sprite_rgb,
    input  logic [RGB_WIDTH-1:0]            wr_data,
    input  logic                            bg_we,
    input  logic                            collision_clear,
    output logic                            hsync,
    output logic                            vsync,
    output logic [RGB_WIDTH-1:0]            rgb,
    output logic [N_SPRITES-1:0]            collision,
    output logic                            frame_strobe
);

    logic                 de_d1;
    logic                 hs_d1;
    logic                 vs_d1;
    logic [RGB_WIDTH-1:0] background;
    logic [RGB_WIDTH-1:0] selected;
    logic                 hit_any;
    logic                 multi_hit;
    logic [N_SPRITES-1:0] collision_next;

    // Stage A: timing inputs wait one cycle for the sprite slots' registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_d1 <= 1'b0;
            hs_d1 <= ~SYNC_ACTIVE;
            vs_d1 <= ~SYNC_ACTIVE;
        end else begin
            de_d1 <= display_on_in;
            hs_d1 <= hsync_in;
            vs_d1 <= vsync_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            background <= '0;
        end else if (bg_we) begin
            background <= wr_data;
        end
    end

    // Lowest index wins; any later hit after the first marks a multi-slot overlap
    always_comb begin
        selected  = background;
        hit_any   = 1'b0;
        multi_hit = 1'b0;
        for (int unsigned i = 0; i < N_SPRITES; i++) begin
            if (sprite_rgb_en[i]) begin
                if (!hit_any) begin
                    selected = sprite_rgb[i*RGB_WIDTH +: RGB_WIDTH];
                end else begin
                    multi_hit = 1'b1;
                end
                hit_any = 1'b1;
            end
        end
    end

    // Clear is applied first so a coincident new collision is never lost
    always_comb begin
        collision_next = collision_clear ? '0 : collision;
        if (de_d1 && multi_hit) begin
            collision_next = collision_next | sprite_rgb_en;
        end
    end

    // Stage B: colour, syncs and status leave together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb          <= '0;
            hsync        <= ~SYNC_ACTIVE;
            vsync        <= ~SYNC_ACTIVE;
            collision    <= '0;
            frame_strobe <= 1'b0;
        end else begin
            rgb          <= de_d1 ? selected : '0;
            hsync        <= hs_d1;
            vsync        <= vs_d1;
            collision    <= collision_next;
            frame_strobe <= (vs_d1 == SYNC_ACTIVE) && (vsync != SYNC_ACTIVE);
        end
    end

endmodule

// File: doc/vdp_mixer.md
# vdp_mixer

Pixel compositor sitting directly downstream of the sprite array and the display timing generator in the VDP. Each cycle it merges the registered `rgb_en`/`rgb` outputs of all sprite slots with a programmable background colour using fixed index priority. It re-aligns hsync/vsync/display-enable with the sprite pipeline and drives the final RGB and sync pins. It also keeps sticky sprite-collision flags and raises a one-cycle frame-start strobe for software.

## Interface
- `N_SPRITES`, 8: number of sprite slots merged; 1..16.
- `RGB_WIDTH`, 3: colour width per pixel (matches the sprite `rgb` width).
- `SYNC_ACTIVE`, 0: active level of hsync/vsync; inactive level is `~SYNC_ACTIVE`.
- `clk` in 1: pixel clock; one pixel per cycle.
- `reset` in 1: asynchronous, active-high.
- `display_on_in` in 1: visible-area flag from the timing generator, same cycle as the `pixel_x`/`pixel_y` it sends to the sprites.
- `hsync_in`, `vsync_in` in 1 each: syncs from the timing generator, same cycle as `display_on_in`.
- `sprite_rgb_en` in `N_SPRITES`: per-slot hit flags; slot i is bit i.
- `sprite_rgb` in `N_SPRITES*RGB_WIDTH`: per-slot colour; slot i is bits `[i*RGB_WIDTH +: RGB_WIDTH]`.
- `wr_data` in `RGB_WIDTH`: background colour write data.
- `bg_we` in 1: load background register from `wr_data`.
- `collision_clear` in 1: clear all collision flags.
- `hsync`, `vsync` out 1 each: aligned syncs to the display.
- `rgb` out `RGB_WIDTH`: final pixel colour.
- `collision` out `N_SPRITES`: sticky per-slot collision flags.
- `frame_strobe` out 1: one-cycle pulse at the start of each aligned vsync.

## Operation
- Stage A (cycle t): the timing inputs are registered into `de_d1`, `hs_d1`, `vs_d1`. The sprite slots register their outputs for the same pixel, so `sprite_rgb_en`/`sprite_rgb` are valid at t+1, aligned with the stage-A registers.
- Stage B (cycle t+1 → output valid at t+2):
  - Priority select: the lowest-index slot with `sprite_rgb_en[i]=1` wins. If no slot hits, `background` is used.
  - `rgb <= de_d1 ? selected : 0`. Output is forced black outside the visible area.
  - `hsync <= hs_d1`, `vsync <= vs_d1`.
- Background register: on `bg_we`, `background <= wr_data`. The new value affects the stage-B pixel computed in the following cycle. Reset value is 0.
- Collision detection, evaluated at stage B:
  - A collision exists when `de_d1=1` and popcount(`sprite_rgb_en`) ≥ 2.
  - Every slot with its enable bit set then gets `collision[i] <= 1`.
  - Flags are sticky until `collision_clear`.
  - If `collision_clear` coincides with a new collision, the new collision's bits end set and all other bits clear; a new event is never lost.
  - Hits while `de_d1=0` are ignored.
- Frame strobe: `frame_strobe <= (vs_d1 == SYNC_ACTIVE) && (vsync != SYNC_ACTIVE)`. This is the rising edge into active vsync, coincident with the first active `vsync` output cycle.

## Timing
- Reset values:
  - `hsync = vsync = ~SYNC_ACTIVE`.
  - `rgb = 0`, `collision = 0`, `frame_strobe = 0`.
  - Internal `de_d1 = 0`, `hs_d1 = vs_d1 = ~SYNC_ACTIVE`, `background = 0`.
- Latency: timing inputs to outputs is 2 cycles; sprite inputs to `rgb` is 1 cycle. Sync and colour for the same pixel leave together.
- Throughput: one pixel per cycle, no stalls, no handshakes.
- Reset mid-frame: all pipeline state returns to reset values immediately (asynchronous). The first valid output is 2 cycles after reset deasserts.
- `bg_we` and `collision_clear` are single-cycle level-sampled. Holding either high repeats the action every cycle.
- All-slots-hit: slot 0 wins, and all `N_SPRITES` collision bits set.

## Test plan
- Reset, then `display_on_in=1`, no sprite hits, `bg_we` with `wr_data=3'b101` → `rgb=3'b101` from 2 cycles after the first visible pixel; before the write, `rgb=0`.
- Slots 2 and 5 hit with colours 3'b010 and 3'b111 at t+1 → `rgb=3'b010` at t+2. `collision=8'b0010_0100` stays set across later clean pixels.
- Assert `collision_clear` on the same cycle as a slots-0-and-1 collision, with `collision` previously `0x24` → `collision=8'b0000_0011`.
- Slots 0 and 1 hit while `display_on_in=0` → `rgb=0`, `collision` unchanged.
- `hsync_in`/`vsync_in` pulse (SYNC_ACTIVE=0) → identical pulse on `hsync`/`vsync` 2 cycles later. `frame_strobe` pulses for exactly one cycle on the first low `vsync` cycle.
- Assert reset mid-line while `rgb=3'b111` and `collision≠0` → outputs immediately `rgb=0`, `collision=0`, syncs inactive. Normal output resumes 2 cycles after release.
